// File: rtl/fetch_pc_gen_if.sv
// Fetch PC generator <-> icache / BPU / instruction-buffer signal bundle.
// master: the PC generator; slave: the surrounding front end.
interface fetch_pc_gen_if;
  logic             stall;
  logic             flush;
  logic [31:0]      flush_target;
  logic             icache_req_ready;
  logic             icache_resp_valid;
  logic [1:0]       is_branch;
  logic [1:0]       pre_taken_or_not;
  logic [31:0]      pre_branch_addr;
  logic             icache_req_valid;
  logic [1:0][31:0] pc_o;
  logic [1:0]       icache_req_slot;
  logic [1:0]       icache_fetch_inst_en;

  modport master (
    input  stall, flush, flush_target, icache_req_ready, icache_resp_valid,
    input  is_branch, pre_taken_or_not, pre_branch_addr,
    output icache_req_valid, pc_o, icache_req_slot, icache_fetch_inst_en
  );

  modport slave (
    output stall, flush, flush_target, icache_req_ready, icache_resp_valid,
    output is_branch, pre_taken_or_not, pre_branch_addr,
    input  icache_req_valid, pc_o, icache_req_slot, icache_fetch_inst_en
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch-address generator: 2-slot packets, single-outstanding icache handshake, flush/BPU redirect.
// Define FETCH_BPU_REDIRECT_EN to enable BPU-predicted redirect and slot1 masking.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic           clk,
  input  logic           rst,
  fetch_pc_gen_if.master bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StDrop = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  slot_q, slot_d;
  logic [1:0]  req_slot;
  logic [31:0] seq_pc;
  logic [31:0] resp_pc;
  logic [1:0]  resp_en;
  logic        req_valid;
  logic [1:0]  fetch_en;
  logic        handshake;

  // A packet never crosses an 8-byte boundary.
  assign req_slot  = pc_q[2] ? 2'b01 : 2'b11;
  assign seq_pc    = {pc_q[31:3], 3'b000} + 32'd8;
  assign handshake = bus.icache_req_ready & ~bus.stall;

`ifdef FETCH_BPU_REDIRECT_EN
  logic taken0, taken1;
  assign taken0  = bus.is_branch[0] & bus.pre_taken_or_not[0];
  assign taken1  = slot_q[1] & bus.is_branch[1] & bus.pre_taken_or_not[1];
  assign resp_pc = (taken0 | taken1) ? bus.pre_branch_addr : seq_pc;
  assign resp_en = taken0 ? (slot_q & 2'b01) : slot_q;
`else
  logic unused_bpu;
  assign unused_bpu = ^{bus.is_branch, bus.pre_taken_or_not, bus.pre_branch_addr};
  assign resp_pc    = seq_pc;
  assign resp_en    = slot_q;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    slot_d    = slot_q;
    req_valid = 1'b0;
    fetch_en  = 2'b00;

    unique case (state_q)
      StIdle: begin
        if (!bus.stall) state_d = StReq;
      end
      StReq: begin
        req_valid = ~bus.stall;
        if (bus.stall) begin
          state_d = StIdle;
        end else if (bus.icache_req_ready) begin
          slot_d  = req_slot;
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.icache_resp_valid) begin
          fetch_en = resp_en;
          pc_d     = resp_pc;
          state_d  = bus.stall ? StIdle : StReq;
        end
      end
      StDrop: begin
        if (bus.icache_resp_valid) state_d = bus.stall ? StIdle : StReq;
      end
      default: state_d = StIdle;
    endcase

    // Flush overrides everything; any in-flight or same-cycle request becomes stale.
    if (bus.flush) begin
      pc_d     = {bus.flush_target[31:2], 2'b00};
      fetch_en = 2'b00;
      unique case (state_q)
        StIdle:         state_d = StReq;
        StReq:          state_d = handshake ? StDrop : StReq;
        StWait, StDrop: state_d = bus.icache_resp_valid ? StReq : StDrop;
        default:        state_d = StReq;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      slot_q  <= 2'b11;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      slot_q  <= slot_d;
    end
  end

  assign bus.icache_req_valid     = req_valid;
  assign bus.icache_fetch_inst_en = fetch_en;
  assign bus.icache_req_slot      = req_slot;
  assign bus.pc_o[0]              = pc_q;
  assign bus.pc_o[1]              = pc_q + 32'd4;

endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Front-end fetch-address generator that sits ahead of the icache and the dual-bank instruction buffer. It produces one 2-instruction fetch packet (pc, pc+4) per request, runs a single-outstanding request handshake with the icache, and redirects on backend flush and BPU-predicted taken branches. It also generates the per-slot `icache_fetch_inst_en` qualifiers that the instruction buffer uses to push instructions. Responses belonging to a superseded fetch stream are discarded.

## Interface
- `RESET_PC`, 32'h1c00_0000: PC loaded on reset.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `stall` in 1: instruction buffer near full; blocks new requests.
- `flush` in 1: backend redirect.
- `flush_target` in 32: redirect PC.
- `icache_req_ready` in 1: icache accepts the request this cycle.
- `icache_resp_valid` in 1: icache returns the outstanding packet.
- `is_branch` in 2: BPU per-slot branch flag, valid with `icache_resp_valid`.
- `pre_taken_or_not` in 2: BPU per-slot taken prediction.
- `pre_branch_addr` in 32: BPU predicted target.
- `icache_req_valid` out 1: request valid.
- `pc_o` out 2x32: slot PCs; `pc_o[1] = pc_o[0] + 4`.
- `icache_req_slot` out 2: slots requested. Both are set when `pc[2]==0`; only 2'b01 when `pc[2]==1` (packet must not cross an 8-byte boundary).
- `icache_fetch_inst_en` out 2: per-slot push enable, asserted in the response cycle only.

## Operation
- Internal state is `pc` (32 bits), the latched request slots, and a 2-bit FSM: `IDLE`, `REQ`, `WAIT`, `DROP`.
- Reset values: `pc = RESET_PC`, FSM = `IDLE`, `icache_req_valid = 0`, `icache_fetch_inst_en = 0`, `pc_o = {RESET_PC+4, RESET_PC}`.
- `IDLE`: go to `REQ` when `!stall`.
- `REQ`:
  - Drive `icache_req_valid = !stall`.
  - If `stall`, go to `IDLE`.
  - If `icache_req_ready && !stall`, latch the slots and go to `WAIT`.
- `WAIT`:
  - On `icache_resp_valid`, drive `icache_fetch_inst_en = latched slots` with the BPU mask applied, update `pc`, and go to `REQ`. If `stall`, go to `IDLE` instead.
- `DROP`:
  - On `icache_resp_valid`, force `icache_fetch_inst_en = 0` and go to `REQ` (or `IDLE` if `stall`).
- Next PC after a kept response, in priority order:
  - Slot0 taken: `pre_branch_addr`; slot1 enable masked to 0.
  - Slot1 requested and taken: `pre_branch_addr`.
  - Otherwise: `{pc[31:3], 3'b000} + 8`.
- All PC arithmetic is 32-bit modulo, so `32'hFFFF_FFF8 + 8` wraps to 0.
- `flush` has highest priority in every state. It loads `pc = {flush_target[31:2], 2'b00}`.
  - `IDLE` or `REQ` without a handshake: next state is `REQ`.
  - `REQ` with a handshake in the same cycle (`icache_req_ready` high): the request is stale, so go to `DROP`.
  - `WAIT` without a response: go to `DROP`.
  - `WAIT` or `DROP` with `icache_resp_valid` in the same cycle: the response is discarded (`icache_fetch_inst_en = 0`) and the next state is `REQ`.
  - `DROP` without a response: stay in `DROP`.

## Timing
- Request accepted at cycle N, response at N+k (k ≥ 1); the next request is driven at N+k+1.
- Peak rate is one packet per two cycles with a 1-cycle icache.
- `icache_fetch_inst_en` is combinational from `icache_resp_valid`, the FSM state, `flush` and the BPU inputs. It is a single-cycle pulse.
- `pc_o` and `icache_req_slot` are registered and stable while `icache_req_valid` is high.
- At most one request is outstanding. A `stall` asserted during `WAIT` does not cancel the in-flight response.
- `icache_resp_valid` in `IDLE` or `REQ` is a protocol error: it is ignored and produces no enables.

## Configuration
- `FETCH_BPU_REDIRECT_EN`:
  - Defined: BPU redirect and slot1 masking behave as above.
  - Undefined: `is_branch`, `pre_taken_or_not` and `pre_branch_addr` are ignored; the next PC is always sequential and only `flush` redirects.

## Test plan
- Reset release with `icache_req_ready = 1` and a 1-cycle response: `pc_o[0]` runs 1c000000, 1c000008, 1c000010; `icache_fetch_inst_en = 2'b11` in each response cycle.
- Flush to 1c000104: the packet is `{1c000108, 1c000104}`, `icache_req_slot = 2'b01`, and the following request is at 1c000108.
- Slot0 predicted taken to 1c000200: `icache_fetch_inst_en = 2'b01` and the next `pc_o[0]` is 1c000200. With the macro undefined: `2'b11`, and the next PC is sequential.
- Flush at 1c000400 while in `WAIT` with the icache delaying 3 cycles: the late response gives `icache_fetch_inst_en = 0`, then a request at 1c000400.
- `stall` held high for 5 cycles from `REQ`: `icache_req_valid = 0` throughout, and the request resumes at an unchanged `pc_o` one cycle after release.
- Async `rst` pulse mid-`WAIT`: outputs return to reset values immediately, and the next request is at 1c000000.
